// File: rtl/kbd_cmd_scheduler.sv
// kbd_cmd_scheduler
//   Decodes PS/2 make codes into game commands, queues them in a small
//   in-order FIFO and releases at most one command per TICK_DIV-cycle
//   window over a valid/ready handshake. Single clock domain (CLOCK_50).
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   key_code_i     scan code, qualified by make_pulse_i
//   make_pulse_i   one-cycle make-event strobe
//   flush_i        clears the queue and returns the issuer to IDLE
//   cmd_ready_i    consumer accepts cmd_code_o this cycle
//   cmd_valid_o    cmd_code_o is valid
//   cmd_code_o     1=L 2=R 3=U 4=D 5=PLACE 6=ROT 7=SEL1 8=SEL2 9=SEL3
//   fifo_count_o   queue occupancy, 0..DEPTH
//   overflow_o     sticky: a command was dropped on a full queue
//   drop_count_o   saturating count of dropped commands
module kbd_cmd_scheduler #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int TICK_DIV = 1_000_000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        key_code_i,
  input  logic              make_pulse_i,
  input  logic              flush_i,
  input  logic              cmd_ready_i,
  output logic              cmd_valid_o,
  output logic [3:0]        cmd_code_o,
  output logic [ADDR_W:0]   fifo_count_o,
  output logic              overflow_o,
  output logic [7:0]        drop_count_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    tick_cnt_q;
  logic [3:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                overflow_q;
  logic [7:0]          drop_cnt_q;

  logic [3:0] dec_cmd;
  logic       tick, pop, push_req, push_ok, drop;

  // Scan-code decode; 0 means "not a command".
  always_comb begin
    dec_cmd = 4'd0;
    case (key_code_i)
      8'h6B, 8'h1C: dec_cmd = 4'd1;
      8'h74, 8'h23: dec_cmd = 4'd2;
      8'h75, 8'h1D: dec_cmd = 4'd3;
      8'h72, 8'h1B: dec_cmd = 4'd4;
      8'h29:        dec_cmd = 4'd5;
      8'h2D:        dec_cmd = 4'd6;
      8'h16:        dec_cmd = 4'd7;
      8'h1E:        dec_cmd = 4'd8;
      8'h26:        dec_cmd = 4'd9;
      default:      dec_cmd = 4'd0;
    endcase
  end

  assign tick     = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign pop      = (state_q == PRESENT) && cmd_ready_i && !flush_i;
  // Flush discards a same-cycle push without counting it as a drop.
  assign push_req = make_pulse_i && (dec_cmd != 4'd0) && !flush_i;
  // A full queue still accepts when the head leaves this cycle; the write
  // lands in the slot being vacated, which becomes the new tail.
  assign push_ok  = push_req && ((count_q < (ADDR_W+1)'(DEPTH)) || pop);
  assign drop     = push_req && !push_ok;

  // Free-running issue-window counter; flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (reset_i)   tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= dec_cmd;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Drop bookkeeping survives flush; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Issue only on a tick seen in IDLE with something queued; ticks in
  // PRESENT are ignored, so each issue needs a fresh window.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (tick && (count_q != '0)) state_d = PRESENT;
        PRESENT: if (cmd_ready_i)             state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs derive from registered state only, so the head is stable
  // for the whole PRESENT interval (pushes write the tail, never the head).
  assign cmd_valid_o  = (state_q == PRESENT);
  assign cmd_code_o   = cmd_valid_o ? mem_q[rd_ptr_q] : 4'd0;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule
